// File: rtl/iobus_timer_pkg.sv
// rtl/iobus_timer_pkg.sv - register offsets, field indices and FSM state type for the IOBUS timer
package otter_iobus_pkg;

  localparam logic [31:0] CTRL_OFS  = 32'h0;
  localparam logic [31:0] LOAD_OFS  = 32'h4;
  localparam logic [31:0] COUNT_OFS = 32'h8;
  localparam logic [31:0] STAT_OFS  = 32'hC;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_AUTO_BIT  = 1;
  localparam int CTRL_IRQ_BIT   = 2;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int STAT_EXP_BIT = 0;
  localparam int STAT_RUN_BIT = 1;

  typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_DONE} tmr_state_t;

endpackage

// File: rtl/iobus_timer_if.sv
// rtl/iobus_timer_if.sv - MCU IOBUS signals seen by the timer, plus its read data and interrupt
interface iobus_timer_if;

  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;
  logic        RD_HIT;
  logic        INTR;

  modport master (
    output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    input  RD_DATA, RD_HIT, INTR
  );

  modport slave (
    input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    output RD_DATA, RD_HIT, INTR
  );

endinterface

// File: rtl/iobus_timer_prescaler.sv
// rtl/iobus_timer_prescaler.sv - divide-by-(PRESC+1) tick generator for the countdown timer
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               EN,
  input  logic               CLR,
  input  logic [PRESC_W-1:0] PRESC,
  output logic               TICK
);

  logic [PRESC_W-1:0] pcnt;

  // A PRESC lowered below pcnt is not caught here: pcnt runs up and wraps before matching.
  assign TICK = EN && (pcnt == PRESC);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pcnt <= '0;
    end else if (CLR || TICK) begin
      pcnt <= '0;
    end else if (EN) begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/iobus_timer.sv
// rtl/iobus_timer.sv - memory-mapped countdown timer on the MCU IOBUS with expiry interrupt
module iobus_timer
  import otter_iobus_pkg::*;
#(
  parameter logic [31:0] BASE_AD = 32'h11200000,
  parameter int          PRESC_W = 8
) (
  input  logic          CLK,
  input  logic          RESET_N,
  iobus_timer_if.slave  bus
);

  tmr_state_t         state_q, state_d;
  logic               ctrl_en, ctrl_auto, ctrl_irq_en;
  logic [PRESC_W-1:0] ctrl_presc;
  logic [31:0]        load_q, count_q;
  logic               exp_q, intr_q;

  logic hit_ctrl, hit_load, hit_count, hit_stat;
  logic wr_ctrl, wr_load, wr_stat, wr_en;
  logic start, stop, run_en, tick, expire;
  logic [31:0] ctrl_rd, stat_rd;

  assign hit_ctrl  = (bus.IOBUS_ADDR == BASE_AD + CTRL_OFS);
  assign hit_load  = (bus.IOBUS_ADDR == BASE_AD + LOAD_OFS);
  assign hit_count = (bus.IOBUS_ADDR == BASE_AD + COUNT_OFS);
  assign hit_stat  = (bus.IOBUS_ADDR == BASE_AD + STAT_OFS);

  assign wr_ctrl = bus.IOBUS_WR && hit_ctrl;
  assign wr_load = bus.IOBUS_WR && hit_load;
  assign wr_stat = bus.IOBUS_WR && hit_stat;
  assign wr_en   = bus.IOBUS_OUT[CTRL_EN_BIT];

  // EN is only ever set together with entering RUN and cleared on leaving it.
  assign ctrl_en = (state_q == TMR_RUN);
  assign start   = wr_ctrl && wr_en && !ctrl_en;
  assign stop    = wr_ctrl && !wr_en && ctrl_en;
  assign run_en  = ctrl_en && !stop;
  assign expire  = tick && (count_q == 32'd0);

  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .EN      (run_en),
    .CLR     (start),
    .PRESC   (ctrl_presc),
    .TICK    (tick)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= TMR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TMR_IDLE, TMR_DONE: begin
        if (start) state_d = TMR_RUN;
      end
      TMR_RUN: begin
        if (stop)                         state_d = TMR_IDLE;
        else if (expire && !ctrl_auto)    state_d = TMR_DONE;
      end
      default: state_d = TMR_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_presc  <= '0;
      load_q      <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_auto   <= bus.IOBUS_OUT[CTRL_AUTO_BIT];
        ctrl_irq_en <= bus.IOBUS_OUT[CTRL_IRQ_BIT];
        ctrl_presc  <= bus.IOBUS_OUT[CTRL_PRESC_LSB +: PRESC_W];
      end
      if (wr_load) load_q <= bus.IOBUS_OUT;
    end
  end

  // A LOAD write only lands in load_q, so a running count is untouched until the next reload.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= load_q;
    end else if (expire) begin
      if (ctrl_auto) count_q <= load_q;
    end else if (tick) begin
      count_q <= count_q - 32'd1;
    end
  end

  // Expiry set beats a same-cycle W1C so software cannot lose an event.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      exp_q  <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      if (expire)                                    exp_q <= 1'b1;
      else if (wr_stat && bus.IOBUS_OUT[STAT_EXP_BIT]) exp_q <= 1'b0;
      intr_q <= expire && ctrl_irq_en;
    end
  end

  always_comb begin
    ctrl_rd                               = '0;
    ctrl_rd[CTRL_EN_BIT]                  = ctrl_en;
    ctrl_rd[CTRL_AUTO_BIT]                = ctrl_auto;
    ctrl_rd[CTRL_IRQ_BIT]                 = ctrl_irq_en;
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_W]    = ctrl_presc;
    stat_rd                               = '0;
    stat_rd[STAT_EXP_BIT]                 = exp_q;
    stat_rd[STAT_RUN_BIT]                 = ctrl_en;
  end

  always_comb begin
    bus.RD_DATA = '0;
    if (hit_ctrl)  bus.RD_DATA = ctrl_rd;
    if (hit_load)  bus.RD_DATA = load_q;
    if (hit_count) bus.RD_DATA = count_q;
    if (hit_stat)  bus.RD_DATA = stat_rd;
  end

  assign bus.RD_HIT = hit_ctrl || hit_load || hit_count || hit_stat;
  assign bus.INTR   = intr_q;

endmodule

// File: tb/tb_iobus_timer.sv
// tb/tb_iobus_timer.sv - directed vector bench for iobus_timer
`timescale 1ns/100ps
module tb_iobus_timer;
  import otter_iobus_pkg::*;

  localparam logic [31:0] BASE    = 32'h11200000;
  localparam logic [31:0] A_CTRL  = BASE + CTRL_OFS;
  localparam logic [31:0] A_LOAD  = BASE + LOAD_OFS;
  localparam logic [31:0] A_COUNT = BASE + COUNT_OFS;
  localparam logic [31:0] A_STAT  = BASE + STAT_OFS;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  iobus_timer_if bus();

  iobus_timer #(.BASE_AD(BASE), .PRESC_W(8)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] d;
  logic        h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] v);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = v;
    bus.IOBUS_WR   = 1'b1;
  endtask

  task automatic drive_idle();
    bus.IOBUS_ADDR = 32'h0;
    bus.IOBUS_OUT  = 32'h0;
    bus.IOBUS_WR   = 1'b0;
  endtask

  // Returns one negedge after the write edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge CLK);
    drive_wr(a, v);
    @(negedge CLK);
    drive_idle();
  endtask

  task automatic read_now(input logic [31:0] a, output logic [31:0] rd, output logic hit);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_WR   = 1'b0;
    #1;
    rd  = bus.RD_DATA;
    hit = bus.RD_HIT;
  endtask

  initial begin
    drive_idle();
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("reset_intr", 32'(bus.INTR), 32'h0);
    RESET_N = 1'b1;

    vecs.push_back('{1'b0, A_CTRL,          32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b0, A_LOAD,          32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b0, A_COUNT,         32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b0, A_STAT,          32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b0, BASE + 32'h10,   32'h0,        1'b0, 32'h0});
    vecs.push_back('{1'b0, BASE + 32'h2,    32'h0,        1'b0, 32'h0});
    vecs.push_back('{1'b0, BASE - 32'h4,    32'h0,        1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,           32'h0,        1'b0, 32'h0});
    vecs.push_back('{1'b1, A_LOAD,          32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_LOAD,          32'h0,        1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b1, A_CTRL,          32'h0000AB06, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_CTRL,          32'h0,        1'b1, 32'h0000AB06});
    vecs.push_back('{1'b1, A_CTRL,          32'hFFFFFFFA, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_CTRL,          32'h0,        1'b1, 32'h0000FF02});
    vecs.push_back('{1'b1, A_COUNT,         32'h00001234, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_COUNT,         32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b1, BASE + 32'h10,   32'h00000055, 1'b0, 32'h0});
    vecs.push_back('{1'b1, BASE + 32'h5,    32'h00000077, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_LOAD,          32'h0,        1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b0, A_CTRL,          32'h0,        1'b1, 32'h0000FF02});
    vecs.push_back('{1'b1, A_STAT,          32'hFFFFFFFF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_STAT,          32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b1, A_CTRL,          32'h0,        1'b0, 32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        @(negedge CLK);
        read_now(vecs[i].addr, d, h);
        check($sformatf("vec%0d_hit", i), 32'(h), 32'(vecs[i].exp_hit));
        check($sformatf("vec%0d_data", i), d, vecs[i].exp_rd);
      end
    end

    // One-shot, LOAD=3, PRESC=0: INTR on the 4th edge after the CTRL write edge.
    bus_write(A_LOAD, 32'd3);
    bus_write(A_CTRL, 32'h5);
    check("oneshot_intr_c0", 32'(bus.INTR), 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      #1;
      check($sformatf("oneshot_intr_c%0d", c), 32'(bus.INTR), 32'(c == 4));
    end
    read_now(A_STAT, d, h);  check("oneshot_stat", d, 32'h1);
    read_now(A_CTRL, d, h);  check("oneshot_ctrl", d, 32'h4);
    read_now(A_COUNT, d, h); check("oneshot_count", d, 32'h0);

    // Auto-reload with PRESC=2; LOAD=4 written mid-period takes effect after the next reload.
    bus_write(A_LOAD, 32'd1);
    bus_write(A_CTRL, 32'h0207);
    for (int c = 1; c <= 70; c++) begin
      @(negedge CLK);
      if (c == 32)      drive_wr(A_LOAD, 32'd4);
      else if (c == 33) drive_idle();
      #1;
      check($sformatf("auto_intr_c%0d", c), 32'(bus.INTR),
            32'(c == 6 || c == 12 || c == 18 || c == 24 || c == 30 || c == 36 || c == 51 || c == 66));
    end
    bus_write(A_CTRL, 32'h0);

    // W1C on the exact expiry edge loses to the set.
    bus_write(A_STAT, 32'h1);
    read_now(A_STAT, d, h); check("w1c_clear_idle", d, 32'h0);
    bus_write(A_LOAD, 32'd2);
    bus_write(A_CTRL, 32'h1);
    @(negedge CLK);
    @(negedge CLK);
    drive_wr(A_STAT, 32'h1);
    @(negedge CLK);
    drive_idle();
    read_now(A_STAT, d, h); check("w1c_race_stat", d, 32'h1);
    bus_write(A_STAT, 32'h1);
    read_now(A_STAT, d, h); check("w1c_after_stat", d, 32'h0);

    // Disable at COUNT=2 holds the count; re-enable restarts from LOAD.
    bus_write(A_LOAD, 32'd5);
    bus_write(A_CTRL, 32'h1);
    repeat (3) @(negedge CLK);
    read_now(A_COUNT, d, h); check("dis_count_before", d, 32'd2);
    drive_wr(A_CTRL, 32'h0);
    @(negedge CLK);
    drive_idle();
    for (int k = 0; k < 10; k++) begin
      read_now(A_COUNT, d, h);
      check($sformatf("dis_hold_%0d", k), d, 32'd2);
      @(negedge CLK);
    end
    read_now(A_STAT, d, h); check("dis_stat", d, 32'h0);
    bus_write(A_CTRL, 32'h1);
    read_now(A_COUNT, d, h); check("resume_count", d, 32'd5);
    read_now(A_STAT, d, h);  check("resume_stat_run", d, 32'h2);
    bus_write(A_CTRL, 32'h0);

    // Max count decrements plainly.
    bus_write(A_LOAD, 32'hFFFFFFFF);
    bus_write(A_CTRL, 32'h1);
    read_now(A_COUNT, d, h); check("max_count0", d, 32'hFFFFFFFF);
    @(negedge CLK);
    read_now(A_COUNT, d, h); check("max_count1", d, 32'hFFFFFFFE);
    bus_write(A_CTRL, 32'h0);

    // LOAD=0 auto: INTR held high every cycle, then a 1 ns async reset pulse.
    bus_write(A_LOAD, 32'd0);
    bus_write(A_CTRL, 32'h7);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("areset_intr_before", 32'(bus.INTR), 32'h1);
    RESET_N = 1'b0;
    #0.4;
    check("areset_intr_during", 32'(bus.INTR), 32'h0);
    #0.6;
    RESET_N = 1'b1;
    read_now(A_COUNT, d, h); check("areset_count", d, 32'h0);
    read_now(A_STAT, d, h);  check("areset_stat", d, 32'h0);
    read_now(A_CTRL, d, h);  check("areset_ctrl", d, 32'h0);
    @(negedge CLK);
    #1;
    check("areset_intr_after", 32'(bus.INTR), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
